// File: rtl/gray_fifo_pkg.sv
// Shared Gray-code helpers and pointer sizing for the async FIFO pointer blocks.
// Helpers work on a MAX_W-wide zero-extended value; callers truncate to their width.
package gray_fifo_pkg;

    localparam int MAX_W = 32;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // MSB-down XOR chain; zero upper bits leave the low-order result unaffected.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_decoder.sv
// Combinational Gray-to-binary converter used on synchronised remote pointers.
module gray_decoder
    import gray_fifo_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Widen into the shared helper and truncate back to WIDTH.
    always_comb begin
        bin_o = WIDTH'(gray2bin(MAX_W'(gray_i)));
    end

endmodule

// File: rtl/gray_encoder.sv
// Combinational binary-to-Gray converter, the mirror of gray_decoder.
module gray_encoder
    import gray_fifo_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Widen into the shared helper and truncate back to WIDTH.
    always_comb begin
        gray_o = WIDTH'(bin2gray(MAX_W'(bin_i)));
    end

endmodule

// File: rtl/gray_wptr_full.sv
// Write-domain pointer of an async FIFO: binary pointer, registered Gray pointer
// for CDC, and registered full / almost_full / fill-level flags.
module gray_wptr_full
    import gray_fifo_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 2**ADDR_W - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ptr_w(ADDR_W)-1:0]  rd_gray_sync,
    output logic                      wr_accept,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [ptr_w(ADDR_W)-1:0]  wr_gray,
    output logic                      full,
    output logic                      almost_full,
    output logic [ptr_w(ADDR_W)-1:0]  wr_level
);

    localparam int PTR_W = ptr_w(ADDR_W);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wr_gray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] rbin_sync_s;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             wr_accept_s;

    gray_encoder #(.WIDTH(PTR_W)) u_wgray_enc (
        .bin_i  (wbin_d),
        .gray_o (wgray_d)
    );

    gray_decoder #(.WIDTH(PTR_W)) u_rbin_dec (
        .gray_i (rd_gray_sync),
        .bin_o  (rbin_sync_s)
    );

    // Pointer advance and fill level for the next cycle.
    always_comb begin
        wr_accept_s = wr_en & ~full_q;
        wbin_d      = wbin_q + PTR_W'(wr_accept_s);
        level_d     = wbin_d - rbin_sync_s;
    end

    // Flag next-state from the next Gray pointer and next fill level.
    always_comb begin
        full_d  = (wgray_d == (rd_gray_sync ^ FULL_MASK));
        afull_d = (level_d >= PTR_W'(AFULL_TH));
    end

    // Pointer and flag registers; every output is loaded in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q    <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wbin_q    <= wbin_d;
            wr_gray_q <= wgray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
        end
    end

    assign wr_accept   = wr_accept_s;
    assign wr_addr     = wbin_q[ADDR_W-1:0];
    assign wr_gray     = wr_gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Directed plus random scoreboard bench for gray_wptr_full (ADDR_W=2, AFULL_TH=2).
module tb_gray_wptr_full;

    localparam int ADDR_W   = 2;
    localparam int AFULL_TH = 2;
    localparam int PTR_W    = ADDR_W + 1;
    localparam int DEPTH    = 2**ADDR_W;
    localparam int MODV     = 2**PTR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [PTR_W-1:0]  rd_gray_sync = '0;
    logic              wr_accept;
    logic [ADDR_W-1:0] wr_addr;
    logic [PTR_W-1:0]  wr_gray;
    logic              full;
    logic              almost_full;
    logic [PTR_W-1:0]  wr_level;

    gray_wptr_full #(.ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_gray_sync (rd_gray_sync),
        .wr_accept    (wr_accept),
        .wr_addr      (wr_addr),
        .wr_gray      (wr_gray),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PTR_W-1:0]  gray;
        logic [ADDR_W-1:0] addr;
        logic              full;
        logic              afull;
        logic [PTR_W-1:0]  level;
        logic              acc;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int wbin_m = 0;
    int rbin_m = 0;
    bit full_m = 1'b0;
    logic [PTR_W-1:0] prev_gray = '0;
    logic [PTR_W-1:0] seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                  3'b111, 3'b101, 3'b100, 3'b000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, predict, then compare just after posedge.
    task automatic drive_step(input bit wr, input int rbin_new);
        exp_t e;
        exp_t got;
        int   lvl;
        bit   acc;
        @(negedge clk);
        wr_en        = wr;
        rbin_m       = rbin_new % MODV;
        rd_gray_sync = PTR_W'(rbin_m ^ (rbin_m >> 1));
        #1;
        acc = wr && !full_m;
        check("wr_accept", 32'(wr_accept), 32'(acc));
        if (acc) wbin_m = (wbin_m + 1) % MODV;
        lvl    = (wbin_m - rbin_m + MODV) % MODV;
        full_m = (lvl == DEPTH);
        e.gray  = PTR_W'(wbin_m ^ (wbin_m >> 1));
        e.addr  = ADDR_W'(wbin_m % DEPTH);
        e.full  = full_m;
        e.afull = (lvl >= AFULL_TH);
        e.level = PTR_W'(lvl);
        e.acc   = acc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("wr_gray", 32'(wr_gray), 32'(got.gray));
        check("wr_addr", 32'(wr_addr), 32'(got.addr));
        check("full", 32'(full), 32'(got.full));
        check("almost_full", 32'(almost_full), 32'(got.afull));
        check("wr_level", 32'(wr_level), 32'(got.level));
        check("gray_onebit", 32'($countones(prev_gray ^ wr_gray)), got.acc ? 32'd1 : 32'd0);
        check("no_overflow", 32'(wr_level <= PTR_W'(DEPTH)), 32'd1);
        prev_gray = wr_gray;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        check("rst_gray", 32'(wr_gray), 32'd0);
        check("rst_level", 32'(wr_level), 32'd0);
        rst = 1'b0;
        drive_step(1'b1, 0);
        drive_step(1'b1, 0);

        // 1: asynchronous reset mid-cycle with wr_en held high
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gray", 32'(wr_gray), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_afull", 32'(almost_full), 32'd0);
        check("arst_level", 32'(wr_level), 32'd0);
        wbin_m = 0;
        full_m = 1'b0;
        prev_gray = '0;
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        drive_step(1'b1, 0);
        check("first_gray", 32'(wr_gray), 32'b001);
        check("first_addr", 32'(wr_addr), 32'd1);

        // 2: complete eight writes with reads draining, pointer wraps to 0
        for (int i = 1; i < 8; i++) begin
            drive_step(1'b1, wbin_m);
            check("seq_gray", 32'(wr_gray), 32'(seq[i]));
        end
        check("wrap_addr", 32'(wr_addr), 32'd0);

        // 3: fill from empty with read pointer at 0
        drive_step(1'b0, 0);
        for (int i = 0; i < 4; i++) drive_step(1'b1, 0);
        check("fill_gray", 32'(wr_gray), 32'b110);
        check("fill_full", 32'(full), 32'd1);
        drive_step(1'b1, 0);
        check("hold_gray", 32'(wr_gray), 32'b110);

        // 4: read advance releases full, held write lands one cycle later
        drive_step(1'b1, 1);
        check("rel_full", 32'(full), 32'd0);
        check("rel_level", 32'(wr_level), 32'd3);
        drive_step(1'b1, 1);
        check("refill_gray", 32'(wr_gray), 32'b111);
        check("refill_full", 32'(full), 32'd1);

        // 5: simultaneous write and read at level 3
        drive_step(1'b0, 2);
        drive_step(1'b1, 3);
        check("simul_level", 32'(wr_level), 32'd3);
        check("simul_full", 32'(full), 32'd0);

        // 6: random writes and legal read advances
        for (int i = 0; i < 1000; i++) begin
            int lvl_cur;
            int adv;
            lvl_cur = (wbin_m - rbin_m + MODV) % MODV;
            adv = (lvl_cur > 0) ? int'($urandom_range(0, 1)) : 0;
            drive_step(1'($urandom_range(0, 1)), rbin_m + adv);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
